tick_sched: RTL and testbench
=============================

# tick_sched

Clock-enable scheduler for the digital clock. One prescaler derives a 1 kHz millisecond tick from the board clock, then a second stage derives the seconds tick and a 1 Hz square wave. The block also owns run/pause, phase clear and fast-set mode, and arbitrates a single beep timer between requesters through a req/ack handshake. Downstream time-keeping, display-scan and buzzer logic stay on `clk_in` and consume these single-cycle enables instead of divided clocks.

## Interface
- `CLK_HZ`, 1_000_000, input clock frequency; must be a multiple of 1000.
- `SEC_MS`, 1000, milliseconds per second tick in normal mode.
- `FAST_MS`, 125, milliseconds per second tick in fast mode; 2 ≤ `FAST_MS` ≤ `SEC_MS`.
- `clk_in`, in, 1, sole clock.
- `rst`, in, 1, synchronous active-high reset.
- `run`, in, 1, level; 1 = seconds stage advances, 0 = paused.
- `clr`, in, 1, one-cycle pulse; restarts seconds phase at 0.
- `fast`, in, 1, level; selects `FAST_MS` period.
- `tick_ms`, out, 1, one-cycle pulse every `CLK_HZ/1000` cycles.
- `tick_sec`, out, 1, one-cycle pulse per second period.
- `sq_1hz`, out, 1, square wave: 0 in first half of the period, 1 in second half.
- `beep_req`, in, 1, level request; held by the requester until `beep_ack`.
- `beep_len`, in, 10, beep duration in ms; sampled with `beep_ack`.
- `beep_ack`, out, 1, one-cycle accept pulse.
- `beep_busy`, out, 1, high from the cycle after ack until the beep ends.
- `beep_out`, out, 1, buzzer enable.

## Operation
- Reset values: all outputs 0; counters 0; beep FSM in IDLE.
- Prescaler:
  - `pre` counts 0..PRE_DIV-1, where PRE_DIV = CLK_HZ/1000, then wraps.
  - Registered `tick_ms` = (pre == PRE_DIV-1).
  - The prescaler runs regardless of `run`.
- Seconds stage:
  - `ms_cnt` advances on `tick_ms` only while `run` = 1.
  - P = `fast` ? `FAST_MS` : `SEC_MS`.
  - When `ms_cnt` ≥ P-1 and it advances, it wraps to 0 and `tick_sec` pulses in the next cycle.
  - The ≥ compare means that switching to fast with `ms_cnt` above the new P wraps on the next advance; no extra ticks are produced.
  - Registered `sq_1hz` = (ms_cnt ≥ P/2), integer division.
- `clr` (highest priority after `rst`):
  - Next cycle: `pre` = 0, `ms_cnt` = 0, `sq_1hz` = 0.
  - No `tick_ms` or `tick_sec` in the cycle following `clr`, even if a wrap coincided.
  - `clr` does not affect the beep FSM.
- Beep FSM, states IDLE → ALIGN → BEEP:
  - **IDLE:** on `beep_req` = 1, pulse `beep_ack` and latch `beep_len`. If len = 0, stay in IDLE. Otherwise go to ALIGN.
  - **ALIGN:** wait for the next `tick_ms`, then go to BEEP and load `rem` = len.
  - **BEEP:** `beep_out` = 1 and `rem` decrements on each `tick_ms`. When `rem` = 1 and `tick_ms`, go to IDLE; `beep_out` drops the next cycle.
  - A request arriving while not in IDLE gets no ack; the requester keeps holding `beep_req`.
  - Back-to-back: the FSM may ack again in the first IDLE cycle.
- Beep is independent of `run` and `fast`.
- `rst` mid-beep aborts the beep with no ack.

## Timing
- First `tick_ms` is at cycle PRE_DIV after `rst` falls (cycle 0 = first non-reset cycle). Later ticks follow every PRE_DIV cycles.
- `tick_sec` is coincident with the `tick_ms` that completes the period; both are registered together.
- `sq_1hz` updates one cycle after `ms_cnt` changes.
- Beep:
  - Ack is 1 cycle after `beep_req` rises, if IDLE.
  - `beep_out` rises 1 cycle after the first `tick_ms` following the ack.
  - `beep_out` lasts exactly len × PRE_DIV cycles.
- `beep_busy` = (state ≠ IDLE), registered.

## Structure
- Package `tick_pkg`:
  - beep state enum (IDLE, ALIGN, BEEP);
  - `BEEP_W` = 10;
  - helper function computing the counter width for PRE_DIV.
- Sub-module `mod_cnt`: modulo counter with enable, sync clear, runtime modulus input and registered wrap pulse. Instantiated for the prescaler (constant modulus) and for the seconds stage (modulus P).
- The beep FSM is inline in `tick_sched`.

## Test plan
All scenarios use `CLK_HZ` = 10_000 (PRE_DIV = 10), `SEC_MS` = 20, `FAST_MS` = 4.
- **Reset release, `run` = 1:** `tick_ms` at cycles 10, 20, 30…; `tick_sec` at cycle 200; `sq_1hz` rises after `ms_cnt` reaches 10.
- **Pause:** `run` = 0 for 50 cycles mid-period → `tick_ms` continues; `tick_sec` is delayed by exactly 50 cycles.
- **`clr` on a wrap cycle:** `clr` in the same cycle that `pre` = 9 and `ms_cnt` = 19 → no tick either stage; next `tick_ms` 10 cycles later; next `tick_sec` 200 cycles after `clr`.
- **Fast switch at `ms_cnt` = 15:** `tick_sec` on the next `tick_ms`; thereafter `tick_sec` every 40 cycles.
- **Beep accept, `beep_len` = 3:** ack 1 cycle after req; `beep_out` high for 30 cycles starting 1 cycle after the next `tick_ms`. A second req during the beep gets no ack until the FSM returns to IDLE.
- **Zero-length and reset abort:** `beep_len` = 0 → ack, `beep_busy` and `beep_out` stay 0. `rst` mid-beep → `beep_out` = 0 and FSM in IDLE the next cycle.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// Shared beep-state encoding, beep length width and counter sizing helper for the tick scheduler.
package tick_pkg;

  localparam int BEEP_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    BEEP  = 2'd2
  } beep_st_e;

  // Bits needed to represent every value 0..n-1, never fewer than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_sched_if.sv
// Beep timer request/ack bundle; master is the requester, slave is the scheduler.
// No backpressure beyond the handshake: the requester holds beep_req and beep_len until beep_ack.
interface tick_sched_if;

  logic                       beep_req;
  logic [tick_pkg::BEEP_W-1:0] beep_len;
  logic                       beep_ack;
  logic                       beep_busy;
  logic                       beep_out;

  modport master (
    output beep_req, beep_len,
    input  beep_ack, beep_busy, beep_out
  );

  modport slave (
    input  beep_req, beep_len,
    output beep_ack, beep_busy, beep_out
  );

endinterface

// File: rtl/tick_sched_mod_cnt.sv
// Modulo counter with enable, sync clear and runtime modulus; wrap is a registered pulse one cycle
// after the advance that rolls over. No backpressure: advances whenever en is high.
module mod_cnt #(
  parameter int W = 4
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic last;

  // >= rather than == so a modulus that shrinks below the count rolls over on the next advance.
  assign last = (cnt >= (modulus - W'(1)));

  always_ff @(posedge clk_in) begin
    if (rst || clr) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= en && last;
      if (en) begin
        cnt <= last ? '0 : cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/tick_sched.sv
// Millisecond/second clock-enable scheduler with run/pause, phase clear, fast mode and a beep timer.
// All outputs registered (one cycle); beep requests are refused (no ack) until the FSM is back in IDLE.
module tick_sched
  import tick_pkg::*;
#(
  parameter int CLK_HZ  = 1_000_000,
  parameter int SEC_MS  = 1000,
  parameter int FAST_MS = 125
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       run,
  input  logic       clr,
  input  logic       fast,
  output logic       tick_ms,
  output logic       tick_sec,
  output logic       sq_1hz,
  tick_sched_if.slave beep
);

  localparam int PRE_DIV = CLK_HZ / 1000;
  localparam int PW      = cnt_w(PRE_DIV + 1);
  localparam int MW      = cnt_w(SEC_MS + 1);
  localparam logic [PW-1:0] PRE_MOD = PW'(PRE_DIV);

  logic [PW-1:0] pre;
  logic          pre_at_max;
  logic [MW-1:0] ms_cnt;
  logic [MW-1:0] period;

  assign period = fast ? MW'(FAST_MS) : MW'(SEC_MS);
  // The seconds stage advances on the same edge that registers tick_ms, so tick_sec lines up with it.
  assign pre_at_max = (pre == (PRE_MOD - PW'(1)));

  mod_cnt #(.W(PW)) u_pre (
    .clk_in  (clk_in),
    .rst     (rst),
    .clr     (clr),
    .en      (1'b1),
    .modulus (PRE_MOD),
    .cnt     (pre),
    .wrap    (tick_ms)
  );

  mod_cnt #(.W(MW)) u_sec (
    .clk_in  (clk_in),
    .rst     (rst),
    .clr     (clr),
    .en      (pre_at_max && run),
    .modulus (period),
    .cnt     (ms_cnt),
    .wrap    (tick_sec)
  );

  always_ff @(posedge clk_in) begin
    if (rst || clr) begin
      sq_1hz <= 1'b0;
    end else begin
      sq_1hz <= (ms_cnt >= (period >> 1));
    end
  end

  beep_st_e          state, state_nxt;
  logic [BEEP_W-1:0] rem, rem_nxt;
  logic              ack_nxt;
  logic              ack_q, busy_q, out_q;

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    ack_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (beep.beep_req) begin
          ack_nxt = 1'b1;
          rem_nxt = beep.beep_len;
          if (beep.beep_len != '0) begin
            state_nxt = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (tick_ms) begin
          state_nxt = BEEP;
        end
      end
      BEEP: begin
        if (tick_ms) begin
          rem_nxt = rem - BEEP_W'(1);
          if (rem == BEEP_W'(1)) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state  <= IDLE;
      rem    <= '0;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      ack_q  <= ack_nxt;
      busy_q <= (state != IDLE);
      out_q  <= (state_nxt == BEEP);
    end
  end

  assign beep.beep_ack  = ack_q;
  assign beep.beep_busy = busy_q;
  assign beep.beep_out  = out_q;

endmodule

// File: tb/tb_tick_sched.sv
// Bench for tick_sched: checkpoint tables, directed corner sequences and randomized traffic
// compared every cycle against a cycle-count / tick-count reference model.
module tb_tick_sched;

  localparam int CLK_HZ  = 10_000;
  localparam int SEC_MS  = 20;
  localparam int FAST_MS = 4;
  localparam int PRE_DIV = CLK_HZ / 1000;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  logic run    = 1'b0;
  logic clr    = 1'b0;
  logic fast   = 1'b0;
  logic tick_ms, tick_sec, sq_1hz;

  tick_sched_if bif();

  tick_sched #(
    .CLK_HZ  (CLK_HZ),
    .SEC_MS  (SEC_MS),
    .FAST_MS (FAST_MS)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .run      (run),
    .clr      (clr),
    .fast     (fast),
    .tick_ms  (tick_ms),
    .tick_sec (tick_sec),
    .sq_1hz   (sq_1hz),
    .beep     (bif)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  // Reference model: cycles since phase start, ms elapsed in the period, ticks seen since ack.
  int m_t = 0, m_ms = 0, m_k = 0, m_len = 0;
  bit m_act = 0;
  bit m_tick = 0, m_sec = 0, m_sq = 0, m_ack = 0, m_busy = 0, m_out = 0;

  typedef struct {
    int   at;
    logic run;
    logic tms;
    logic tsec;
    logic sq;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %b, expected %b", nm, cyc_n, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit rn, input bit f,
                            input bit rq, input int ln);
    int p;
    bit tick_prev;
    tick_prev = m_tick;
    p = f ? FAST_MS : SEC_MS;
    if (r) begin
      m_t = 0; m_ms = 0; m_act = 0; m_k = 0;
      m_tick = 0; m_sec = 0; m_sq = 0; m_ack = 0; m_busy = 0; m_out = 0;
    end else begin
      m_busy = m_act;
      m_ack  = !m_act && rq;
      if (m_act) begin
        if (tick_prev) begin
          m_k++;
          if (m_k == m_len + 1) m_act = 0;
        end
      end else if (rq && ln != 0) begin
        m_act = 1; m_k = 0; m_len = ln;
      end
      m_out = m_act && (m_k >= 1);
      if (c) begin
        m_t = 0; m_ms = 0; m_sq = 0; m_tick = 0; m_sec = 0;
      end else begin
        m_sq   = (m_ms >= p / 2);
        m_t++;
        m_tick = (m_t % PRE_DIV == 0);
        m_sec  = 0;
        if (m_tick && rn) begin
          if (m_ms >= p - 1) begin
            m_ms = 0; m_sec = 1;
          end else begin
            m_ms++;
          end
        end
      end
    end
  endtask

  task automatic cyc();
    bit r, c, rn, f, rq;
    int ln;
    r = rst; c = clr; rn = run; f = fast; rq = bif.beep_req; ln = int'(bif.beep_len);
    @(posedge clk_in);
    #1;
    model_step(r, c, rn, f, rq, ln);
    cyc_n++;
    chk("model.tick_ms", tick_ms, m_tick);
    chk("model.tick_sec", tick_sec, m_sec);
    chk("model.sq_1hz", sq_1hz, m_sq);
    chk("model.beep_ack", bif.beep_ack, m_ack);
    chk("model.beep_busy", bif.beep_busy, m_busy);
    chk("model.beep_out", bif.beep_out, m_out);
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; run = 1'b0; fast = 1'b0; bif.beep_req = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc_n = 0;
  endtask

  task automatic advance(input int to);
    while (cyc_n < to) cyc();
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return tick_ms;
      1:       return tick_sec;
      2:       return bif.beep_ack;
      default: return bif.beep_out;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      cyc();
      if (sig(which)) begin
        at = cyc_n;
        break;
      end
    end
  endtask

  task automatic run_table(input string nm);
    foreach (tbl[i]) begin
      run = tbl[i].run;
      advance(tbl[i].at);
      chk($sformatf("%s[%0d].tick_ms", nm, i), tick_ms, tbl[i].tms);
      chk($sformatf("%s[%0d].tick_sec", nm, i), tick_sec, tbl[i].tsec);
      chk($sformatf("%s[%0d].sq_1hz", nm, i), sq_1hz, tbl[i].sq);
    end
  endtask

  initial begin
    int at, n_hi, first_hi, bad_ack;
    bif.beep_req = 1'b0;
    bif.beep_len = '0;

    // Reset release with run held high.
    do_reset();
    chk("rst.beep_ack", bif.beep_ack, 1'b0);
    chk("rst.beep_busy", bif.beep_busy, 1'b0);
    chk("rst.beep_out", bif.beep_out, 1'b0);
    tbl = {};
    tbl.push_back('{0,   1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{9,   1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{10,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{11,  1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{20,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{100, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{101, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{199, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{200, 1'b1, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{201, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{210, 1'b1, 1'b1, 1'b0, 1'b0});
    run_table("release");

    // Pause for cycles 50..99: tick_ms keeps going, tick_sec slips from 200 to 250.
    do_reset();
    tbl = {};
    tbl.push_back('{50,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{60,  1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{95,  1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{100, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{200, 1'b1, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{250, 1'b1, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{251, 1'b1, 1'b0, 1'b0, 1'b0});
    run_table("pause");

    // clr in the cycle where both stages would wrap.
    do_reset();
    run = 1'b1;
    advance(199);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr.no_tick_ms", tick_ms, 1'b0);
    chk("clr.no_tick_sec", tick_sec, 1'b0);
    wait_sig(0, 20, at);
    chk_int("clr.next_tick_ms_cycle", at, 210);
    wait_sig(1, 300, at);
    chk_int("clr.next_tick_sec_cycle", at, 400);

    // Switch to fast with ms_cnt = 15: wraps on the next tick, then every 4 ms.
    do_reset();
    run = 1'b1;
    advance(151);
    fast = 1'b1;
    wait_sig(1, 30, at);
    chk_int("fast.first_sec_cycle", at, 160);
    wait_sig(1, 60, at);
    chk_int("fast.second_sec_cycle", at, 200);
    wait_sig(1, 60, at);
    chk_int("fast.third_sec_cycle", at, 240);
    fast = 1'b0;

    // Beep of 3 ms; a second request during the beep waits for IDLE.
    do_reset();
    advance(3);
    bif.beep_req = 1'b1;
    bif.beep_len = 10'd3;
    cyc();
    chk("beep.ack_after_req", bif.beep_ack, 1'b1);
    bif.beep_req = 1'b0;
    n_hi = 0; first_hi = -1; bad_ack = 0;
    while (cyc_n < 41) begin
      if (cyc_n == 20) begin
        bif.beep_req = 1'b1;
        bif.beep_len = 10'd2;
      end
      cyc();
      if (bif.beep_out) begin
        n_hi++;
        if (first_hi < 0) first_hi = cyc_n;
      end
      if (bif.beep_ack) bad_ack++;
    end
    chk_int("beep.first_out_cycle", first_hi, 11);
    chk_int("beep.out_cycles", n_hi, 30);
    chk_int("beep.ack_while_busy", bad_ack, 0);
    wait_sig(2, 10, at);
    bif.beep_req = 1'b0;
    chk_int("beep.second_ack_cycle", at, 42);
    advance(cyc_n + 40);

    // Zero-length request, then reset in the middle of a beep.
    do_reset();
    advance(2);
    bif.beep_req = 1'b1;
    bif.beep_len = 10'd0;
    cyc();
    chk("zero.ack", bif.beep_ack, 1'b1);
    bif.beep_req = 1'b0;
    n_hi = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (bif.beep_busy || bif.beep_out) n_hi++;
    end
    chk_int("zero.busy_or_out_cycles", n_hi, 0);
    bif.beep_req = 1'b1;
    bif.beep_len = 10'd5;
    cyc();
    chk("abort.ack", bif.beep_ack, 1'b1);
    bif.beep_req = 1'b0;
    wait_sig(3, 30, at);
    chk_int("abort.out_rise_cycle", at, 21);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk("abort.out_low", bif.beep_out, 1'b0);
    chk("abort.busy_low", bif.beep_busy, 1'b0);
    rst = 1'b0;
    cyc_n = 0;
    bif.beep_req = 1'b1;
    bif.beep_len = 10'd1;
    cyc();
    chk("abort.idle_acks", bif.beep_ack, 1'b1);
    bif.beep_req = 1'b0;
    advance(cyc_n + 30);

    // Randomized traffic against the model.
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      if ($urandom_range(0, 31) == 0) fast = ~fast;
      clr = ($urandom_range(0, 255) == 0);
      rst = ($urandom_range(0, 499) == 0);
      if (!bif.beep_req && $urandom_range(0, 7) == 0) begin
        bif.beep_req = 1'b1;
        bif.beep_len = 10'($urandom_range(0, 3));
      end
      cyc();
      if (bif.beep_ack || rst) bif.beep_req = 1'b0;
    end
    rst = 1'b0;
    clr = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
